// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state type and baud divider helper for the UART blocks
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        BREAK
    } rx_state_t;

    // Clocks per oversample tick; never below 1 so the tick generator stays legal.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int d;
        d = clk_hz / (baud * oversample);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one-clk tick every DIV clocks with phase restart
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // divider counter; restart realigns the tick phase to the detected start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST) && !restart;

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver; UART_RX_MAJORITY_EN enables 2-of-3 bit voting
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Din,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    rx_state_t            state;
    rx_state_t            next_state;
    logic [1:0]           sync;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 start_edge;
    logic                 tick;
    logic                 sample_evt;
    logic                 sample_bit;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_c;
    logic                 frm_err_c;
    logic                 last_stop;
    logic                 exp_par;
    logic                 stop_done;

    // two-flop synchroniser for the asynchronous line, idle level 1; rx_prev feeds edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], Din};
            rx_prev <= sync[1];
        end
    end

    assign rx_s       = sync[1];
    assign start_edge = (state == IDLE) && rx_prev && !rx_s;

    uart_baud_tick #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(start_edge),
        .tick   (tick)
    );

    // tick position inside the current bit; phase zero is the start edge, so mid-bit repeats every bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (start_edge) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] TICK_EARLY  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_DECIDE = TW'(OVERSAMPLE / 2 + 1);

    logic [1:0] early;

    // keep the two samples preceding the decision tick for the vote
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            early <= 2'b11;
        end else if (tick && ((tick_cnt == TICK_EARLY) || (tick_cnt == TICK_MID))) begin
            early <= {early[0], rx_s};
        end
    end

    assign sample_evt = tick && (tick_cnt == TICK_DECIDE);
    assign sample_bit = (early[1] & early[0]) | (early[1] & rx_s) | (early[0] & rx_s);
`else
    assign sample_evt = tick && (tick_cnt == TICK_MID);
    assign sample_bit = rx_s;
`endif

    assign exp_par   = (PARITY_MODE == PAR_ODD) ? ~(^shreg) : (^shreg);
    assign stop_done = (state == STOP) && sample_evt && (bit_cnt == STOP_LAST);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state logic; BREAK waits for the line to go high so a held-low line yields one frame only
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    next_state = START;
                end
            end
            START: begin
                if (sample_evt) begin
                    next_state = sample_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_evt && (bit_cnt == DATA_LAST)) begin
                    next_state = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (sample_evt) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (stop_done) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = last_stop ? IDLE : BREAK;
            end
            BREAK: begin
                if (rx_s) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // status outputs decoded from the state
    always_comb begin
        valid = 1'b0;
        busy  = 1'b0;
        case (state)
            START, DATA, PARITY, STOP: busy = 1'b1;
            DONE:                      valid = 1'b1;
            default:                   ;
        endcase
    end

    // frame datapath: payload shift register (LSB first), bit/stop counter, error candidates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            par_err_c <= 1'b0;
            frm_err_c <= 1'b0;
            last_stop <= 1'b1;
        end else begin
            case (state)
                START: begin
                    bit_cnt   <= '0;
                    par_err_c <= 1'b0;
                    frm_err_c <= 1'b0;
                end
                DATA: begin
                    if (sample_evt) begin
                        shreg   <= {sample_bit, shreg[DATA_BITS-1:1]};
                        bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (sample_evt) begin
                        par_err_c <= (sample_bit != exp_par);
                    end
                end
                STOP: begin
                    if (sample_evt) begin
                        bit_cnt   <= bit_cnt + 1'b1;
                        last_stop <= sample_bit;
                        if (!sample_bit) begin
                            frm_err_c <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // result registers load with the final stop sample so they are new in the DONE (valid) cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Dout       <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else if (stop_done) begin
            Dout       <= shreg;
            frame_err  <= frm_err_c | !sample_bit;
            parity_err <= par_err_c;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param in 8N1, 8E1 and 7O2 builds
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int CLK_HZ = 3_200_000;
    localparam int BAUD   = 100_000;
    localparam int OS     = 16;
    localparam int BIT    = 32;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    typedef struct {
        int         cfg;
        logic [8:0] data;
        logic       bad_par;
        logic [8:0] exp_d;
        logic       exp_pe;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din0 = 1'b1, din1 = 1'b1, din2 = 1'b1;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic       v0, v1, v2, b0, b1, b2, fe0, fe1, fe2, pe0, pe1, pe2;

    rec_t q0[$], q1[$], q2[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_run = 0;
    int   last_busy = 0;
    vec_t vecs[7];

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .Din(din0), .Dout(d0), .valid(v0), .busy(b0), .frame_err(fe0), .parity_err(pe0));
    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .Din(din1), .Dout(d1), .valid(v1), .busy(b1), .frame_err(fe1), .parity_err(pe1));
    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst(rst), .Din(din2), .Dout(d2), .valid(v2), .busy(b2), .frame_err(fe2), .parity_err(pe2));

    always @(negedge clk) begin
        if (v0) q0.push_back(rec_t'{d: {1'b0, d0}, pe: pe0, fe: fe0});
        if (v1) q1.push_back(rec_t'{d: {1'b0, d1}, pe: pe1, fe: fe1});
        if (v2) q2.push_back(rec_t'{d: {2'b00, d2}, pe: pe2, fe: fe2});
        if (b0) busy_run++;
        else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run  = 0;
        end
    end

    function automatic int nbits(int cfg);
        return (cfg == 2) ? 7 : 8;
    endfunction

    function automatic int pmode(int cfg);
        return (cfg == 1) ? PAR_EVEN : ((cfg == 2) ? PAR_ODD : PAR_NONE);
    endfunction

    function automatic int nstop(int cfg);
        return (cfg == 2) ? 2 : 1;
    endfunction

    function automatic logic model_pe(int cfg, logic [8:0] data, logic parbit);
        int ones;
        ones = 0;
        if (pmode(cfg) == PAR_NONE) return 1'b0;
        for (int i = 0; i < nbits(cfg); i++) ones += int'(data[i]);
        ones += int'(parbit);
        return (pmode(cfg) == PAR_EVEN) ? ((ones % 2) != 0) : ((ones % 2) != 1);
    endfunction

    function automatic int qsize(int cfg);
        case (cfg)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic clear_q();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_din(int cfg, logic v);
        case (cfg)
            0:       din0 = v;
            1:       din1 = v;
            default: din2 = v;
        endcase
    endtask

    task automatic drive_bit(int cfg, logic v);
        set_din(cfg, v);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(int cfg, logic [8:0] data, logic bad_par, logic stop_v, int max_bits, output logic parbit);
        logic [15:0] bits;
        int n;
        int ones;
        bits   = '1;
        n      = 0;
        ones   = 0;
        parbit = 1'b0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < nbits(cfg); i++) begin
            bits[n] = data[i];
            ones += int'(data[i]);
            n++;
        end
        if (pmode(cfg) != PAR_NONE) begin
            parbit  = ((pmode(cfg) == PAR_EVEN) ? ((ones % 2) == 1) : ((ones % 2) == 0)) ^ bad_par;
            bits[n] = parbit;
            n++;
        end
        for (int i = 0; i < nstop(cfg); i++) begin
            bits[n] = stop_v;
            n++;
        end
        if (max_bits < n) n = max_bits;
        for (int i = 0; i < n; i++) drive_bit(cfg, bits[i]);
    endtask

    task automatic expect_rec(string name, int cfg, logic [8:0] ed, logic epe, logic efe);
        rec_t r;
        check({name, " valid seen"}, int'(qsize(cfg) > 0), 1);
        if (qsize(cfg) > 0) begin
            case (cfg)
                0:       r = q0.pop_front();
                1:       r = q1.pop_front();
                default: r = q2.pop_front();
            endcase
            check({name, " Dout"}, int'(r.d), int'(ed));
            check({name, " parity_err"}, int'(r.pe), int'(epe));
            check({name, " frame_err"}, int'(r.fe), int'(efe));
        end
    endtask

    initial begin
        logic       pb;
        logic       pb2;
        int         cfg;
        logic [8:0] data;
        logic [8:0] mask;
        logic       bad;

        vecs[0] = '{0, 9'h0A5, 1'b0, 9'h0A5, 1'b0};
        vecs[1] = '{1, 9'h03C, 1'b0, 9'h03C, 1'b0};
        vecs[2] = '{1, 9'h03C, 1'b1, 9'h03C, 1'b1};
        vecs[3] = '{2, 9'h055, 1'b0, 9'h055, 1'b0};
        vecs[4] = '{2, 9'h02A, 1'b1, 9'h02A, 1'b1};
        vecs[5] = '{0, 9'h0FF, 1'b0, 9'h0FF, 1'b0};
        vecs[6] = '{1, 9'h001, 1'b1, 9'h001, 1'b1};

        wait_clk(5);
        check("reset Dout 8n1", int'(d0), 0);
        check("reset Dout 7o2", int'(d2), 0);
        check("reset valid", int'({v0, v1, v2}), 0);
        check("reset busy", int'({b0, b1, b2}), 0);
        check("reset errs", int'({fe0, fe1, fe2, pe0, pe1, pe2}), 0);
        rst = 1'b1;
        wait_clk(2 * BIT);

        for (int i = 0; i < 7; i++) begin
            clear_q();
            send_frame(vecs[i].cfg, vecs[i].data, vecs[i].bad_par, 1'b1, 99, pb);
            wait_clk(2 * BIT);
            check($sformatf("vec%0d count", i), qsize(vecs[i].cfg), 1);
            expect_rec($sformatf("vec%0d", i), vecs[i].cfg, vecs[i].exp_d, vecs[i].exp_pe, 1'b0);
            if (vecs[i].cfg == 0 && vecs[i].data == 9'h0A5)
                check("busy length A5", int'(last_busy >= 280 && last_busy <= 330), 1);
        end

        clear_q();
        send_frame(0, 9'h0F0, 1'b0, 1'b0, 99, pb);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        check("break count", qsize(0), 1);
        expect_rec("break", 0, 9'h0F0, 1'b0, 1'b1);
        check("frame_err held", int'(fe0), 1);
        send_frame(0, 9'h012, 1'b0, 1'b1, 99, pb);
        wait_clk(2 * BIT);
        check("after break count", qsize(0), 1);
        expect_rec("after break", 0, 9'h012, 1'b0, 1'b0);

        clear_q();
        set_din(0, 1'b0);
        wait_clk(6);
        check("glitch busy rise", int'(b0), 1);
        wait_clk(4);
        set_din(0, 1'b1);
        wait_clk(30);
        check("glitch busy fall", int'(b0), 0);
        wait_clk(2 * BIT);
        check("glitch no valid", qsize(0), 0);

        clear_q();
        send_frame(2, 9'h055, 1'b0, 1'b1, 99, pb);
        send_frame(2, 9'h02A, 1'b0, 1'b1, 99, pb2);
        wait_clk(2 * BIT);
        check("b2b count", qsize(2), 2);
        expect_rec("b2b first", 2, 9'h055, model_pe(2, 9'h055, pb), 1'b0);
        expect_rec("b2b second", 2, 9'h02A, model_pe(2, 9'h02A, pb2), 1'b0);

        for (int i = 0; i < 12; i++) begin
            clear_q();
            cfg  = int'($urandom_range(0, 2));
            mask = 9'((1 << nbits(cfg)) - 1);
            data = 9'($urandom) & mask;
            bad  = (pmode(cfg) != PAR_NONE) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_frame(cfg, data, bad, 1'b1, 99, pb);
            wait_clk(2 * BIT + int'($urandom_range(0, 20)));
            check($sformatf("rand%0d count", i), qsize(cfg), 1);
            expect_rec($sformatf("rand%0d cfg%0d", i, cfg), cfg, data, model_pe(cfg, data, pb), 1'b0);
        end

        clear_q();
        send_frame(0, 9'h081, 1'b0, 1'b1, 5, pb);
        check("mid-frame busy", int'(b0), 1);
        rst = 1'b0;
        @(negedge clk);
        check("in reset Dout", int'(d0), 0);
        check("in reset valid busy", int'({v0, b0}), 0);
        check("in reset errs", int'({fe0, pe0}), 0);
        set_din(0, 1'b1);
        wait_clk(10);
        rst = 1'b1;
        wait_clk(2 * BIT);
        send_frame(0, 9'h081, 1'b0, 1'b1, 99, pb);
        wait_clk(2 * BIT);
        check("post reset count", qsize(0), 1);
        expect_rec("post reset", 0, 9'h081, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
